vga_timing_painter: RTL and testbench

Parametrised VGA timing and pixel output stage. It generates the horizontal and vertical counters and presents them to the pixel source. It accepts the returned colour after a fixed source latency and drives registered RGB, hsync, vsync, sync and blank to the DAC, all aligned to the same pixel. It adds selectable output modes and adjustable timing and colour width.

---
 rtl/vga_timing_painter.sv | 171 +++++++++++++++++
 tb/tb_vga_timing_painter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_painter.sv
// VGA timing generator and registered pixel output stage.
// Counters drive the pixel source; a delay line realigns timing with the returned colour.
module vga_timing_painter #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned CH_W     = 8,
   parameter int unsigned PIPE     = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pix_en,
   input  logic [1:0]        mode,
   input  logic [3*CH_W-1:0] pixel_color,
   input  logic [3*CH_W-1:0] bg_color,
   output logic [9:0]        h_count,
   output logic [9:0]        v_count,
   output logic              vid_on,
   output logic              frame_start,
   output logic [CH_W-1:0]   blue,
   output logic [CH_W-1:0]   green,
   output logic [CH_W-1:0]   red,
   output logic              hsync_n,
   output logic              vsync_n,
   output logic              sync_n,
   output logic              blank_n
);

   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_BEG   = H_ACTIVE + H_FP;
   localparam int unsigned HS_END   = HS_BEG + H_SYNC;
   localparam int unsigned VS_BEG   = V_ACTIVE + V_FP;
   localparam int unsigned VS_END   = VS_BEG + V_SYNC;
   localparam int unsigned BAR_W    = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
   localparam int unsigned TAP_W    = 13;
   localparam int unsigned CNT_W    = 10;
   localparam int unsigned CMP_W    = 11;
   localparam logic [TAP_W-1:0] TAP_IDLE = {1'b0, 1'b1, 1'b1, 10'd0};

   logic             h_last;
   logic             v_last;
   logic [CMP_W-1:0] h_ext;
   logic [CMP_W-1:0] v_ext;
   logic             hs_raw;
   logic             vs_raw;
   logic [1:0]       act_mode;
   logic [TAP_W-1:0] tap_in;
   logic [TAP_W-1:0] tap_out;
   logic             d_vid;
   logic             d_hs;
   logic             d_vs;
   logic [CNT_W-1:0] d_h;
   logic [CNT_W-1:0] bar_idx;
   logic [2:0]       bar_bgr;
   logic [3*CH_W-1:0] bar_color;
   logic [3*CH_W-1:0] sel_color;

   assign h_last = (h_count == CNT_W'(H_TOTAL - 1));
   assign v_last = (v_count == CNT_W'(V_TOTAL - 1));
   assign h_ext  = {1'b0, h_count};
   assign v_ext  = {1'b0, v_count};

   // Request-side timing decode, one pixel ahead of the delay line
   assign vid_on      = (h_ext < CMP_W'(H_ACTIVE)) && (v_ext < CMP_W'(V_ACTIVE));
   assign hs_raw      = !((h_ext >= CMP_W'(HS_BEG)) && (h_ext < CMP_W'(HS_END)));
   assign vs_raw      = !((v_ext >= CMP_W'(VS_BEG)) && (v_ext < CMP_W'(VS_END)));
   assign frame_start = pix_en && !reset && (h_count == '0) && (v_count == '0);
   assign sync_n      = 1'b0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_count <= '0;
         v_count <= '0;
      end else if (pix_en) begin
         if (h_last) begin
            h_count <= '0;
            v_count <= v_last ? '0 : v_count + CNT_W'(1);
         end else begin
            h_count <= h_count + CNT_W'(1);
         end
      end
   end

   // Mode is only sampled at the top of a frame so a frame never mixes modes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         act_mode <= 2'd3;
      end else if (frame_start) begin
         act_mode <= mode;
      end
   end

   assign tap_in = {vid_on, hs_raw, vs_raw, h_count};

   if (PIPE == 0) begin : g_no_dly
      assign tap_out = tap_in;
   end else begin : g_dly
      logic [TAP_W-1:0] stage [PIPE];

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            for (int i = 0; i < int'(PIPE); i++) stage[i] <= TAP_IDLE;
         end else if (pix_en) begin
            stage[0] <= tap_in;
            for (int i = 1; i < int'(PIPE); i++) stage[i] <= stage[i-1];
         end
      end

      assign tap_out = stage[PIPE-1];
   end

   assign d_vid = tap_out[12];
   assign d_hs  = tap_out[11];
   assign d_vs  = tap_out[10];
   assign d_h   = tap_out[9:0];

   // Eight vertical bars, {b,g,r} per bar; anything past bar 7 is black
   always_comb begin
      bar_bgr = 3'b000;
      bar_idx = d_h / CNT_W'(BAR_W);
      case (bar_idx)
         10'd0:   bar_bgr = 3'b111;
         10'd1:   bar_bgr = 3'b011;
         10'd2:   bar_bgr = 3'b110;
         10'd3:   bar_bgr = 3'b010;
         10'd4:   bar_bgr = 3'b101;
         10'd5:   bar_bgr = 3'b001;
         10'd6:   bar_bgr = 3'b100;
         default: bar_bgr = 3'b000;
      endcase
   end

   assign bar_color = {{CH_W{bar_bgr[2]}}, {CH_W{bar_bgr[1]}}, {CH_W{bar_bgr[0]}}};

   always_comb begin
      sel_color = '0;
      case (act_mode)
         2'd0:    sel_color = pixel_color;
         2'd1:    sel_color = bg_color;
         2'd2:    sel_color = bar_color;
         default: sel_color = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blue    <= '0;
         green   <= '0;
         red     <= '0;
         blank_n <= 1'b0;
         hsync_n <= 1'b1;
         vsync_n <= 1'b1;
      end else if (pix_en) begin
         hsync_n <= d_hs;
         vsync_n <= d_vs;
         blank_n <= d_vid;
         if (d_vid) begin
            {blue, green, red} <= sel_color;
         end else begin
            {blue, green, red} <= '0;
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_painter.sv
// Directed bench on a shrunk 24x8 raster: PIPE=2/CH_W=8 main instance, PIPE=0/CH_W=4 second instance.
module tb_vga_timing_painter;

   logic        clk;
   logic        reset;
   logic        pix_en;
   logic [1:0]  mode;
   logic [23:0] pixel_color;
   logic [23:0] bg_color;
   logic [9:0]  h_count, v_count;
   logic        vid_on, frame_start;
   logic [7:0]  blue, green, red;
   logic        hsync_n, vsync_n, sync_n, blank_n;

   logic [11:0] pixel_color4;
   logic [11:0] bg_color4;
   logic [9:0]  h_count4, v_count4;
   logic        vid_on4, frame_start4;
   logic [3:0]  blue4, green4, red4;
   logic        hsync_n4, vsync_n4, sync_n4, blank_n4;

   int errors = 0;
   int checks = 0;
   int tick_n = 0;
   int vs_low = 0;
   int hs_low = 0;
   int fs_cnt = 0;

   logic [7:0] ph1, pv1, ph2, pv2;

   vga_timing_painter #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .CH_W(8), .PIPE(2)
   ) dut (
      .clk(clk), .reset(reset), .pix_en(pix_en), .mode(mode),
      .pixel_color(pixel_color), .bg_color(bg_color),
      .h_count(h_count), .v_count(v_count), .vid_on(vid_on),
      .frame_start(frame_start), .blue(blue), .green(green), .red(red),
      .hsync_n(hsync_n), .vsync_n(vsync_n), .sync_n(sync_n), .blank_n(blank_n)
   );

   vga_timing_painter #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .CH_W(4), .PIPE(0)
   ) dut4 (
      .clk(clk), .reset(reset), .pix_en(pix_en), .mode(mode),
      .pixel_color(pixel_color4), .bg_color(bg_color4),
      .h_count(h_count4), .v_count(v_count4), .vid_on(vid_on4),
      .frame_start(frame_start4), .blue(blue4), .green(green4), .red(red4),
      .hsync_n(hsync_n4), .vsync_n(vsync_n4), .sync_n(sync_n4), .blank_n(blank_n4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Pixel source model: returns {0, v, h} of a coordinate two ticks later
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         ph1 <= '0; pv1 <= '0; ph2 <= '0; pv2 <= '0;
      end else if (pix_en) begin
         ph1 <= h_count[7:0];
         pv1 <= v_count[7:0];
         ph2 <= ph1;
         pv2 <= pv1;
      end
   end

   assign pixel_color  = {8'h00, pv2, ph2};
   assign pixel_color4 = 12'h000;
   assign bg_color4    = 12'h3A5;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      pix_en = 1'b1;
      #1;
      if (frame_start) fs_cnt++;
      @(negedge clk);
      pix_en = 1'b0;
      tick_n++;
      if (!vsync_n) vs_low++;
      if (!hsync_n) hs_low++;
   endtask

   task automatic run_to(input int n);
      while (tick_n < n) tick();
   endtask

   initial begin
      reset    = 1'b1;
      pix_en   = 1'b0;
      mode     = 2'd0;
      bg_color = 24'h000000;
      #12;
      chk("rst_rgb", {8'h0, blue, green, red}, 32'h0);
      chk("rst_blank", blank_n, 1'b0);
      chk("rst_hsync", hsync_n, 1'b1);
      chk("rst_vsync", vsync_n, 1'b1);
      chk("rst_sync", sync_n, 1'b0);
      chk("rst_fs", frame_start, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      chk("rst_h", h_count, 10'd0);
      chk("rst_v", v_count, 10'd0);
      chk("rst_vid_on", vid_on, 1'b1);

      // Frame 0, mode 0: pass-through pixels, latency 3 ticks
      run_to(2);
      chk("t2_blank", blank_n, 1'b0);
      run_to(3);
      chk("t3_blank", blank_n, 1'b1);
      chk("t3_red", red, 8'h00);
      chk("t3_green", green, 8'h00);
      run_to(4);
      chk("t4_red", red, 8'h01);
      repeat (3) @(negedge clk);
      chk("hold_h", h_count, 10'd4);
      chk("hold_red", red, 8'h01);
      run_to(18);
      chk("t18_red", red, 8'h0F);
      chk("t18_blank", blank_n, 1'b1);
      run_to(19);
      chk("t19_blank", blank_n, 1'b0);
      chk("t19_rgb", {8'h0, blue, green, red}, 32'h0);
      run_to(20);
      chk("t20_hs", hsync_n, 1'b1);
      run_to(21);
      chk("t21_hs", hsync_n, 1'b0);
      run_to(23);
      chk("t23_hs", hsync_n, 1'b0);
      run_to(24);
      chk("t24_hs", hsync_n, 1'b1);
      run_to(27);
      chk("t27_line1", {8'h0, blue, green, red}, 32'h000100);
      chk("t27_blank", blank_n, 1'b1);
      run_to(50);
      mode = 2'd2;
      run_to(80);
      chk("t80_still_mode0", {8'h0, blue, green, red}, 32'h000305);
      run_to(122);
      chk("t122_vs", vsync_n, 1'b1);
      run_to(123);
      chk("t123_vs", vsync_n, 1'b0);
      run_to(170);
      chk("t170_vs", vsync_n, 1'b0);
      run_to(171);
      chk("t171_vs", vsync_n, 1'b1);
      run_to(191);
      chk("t191_h", h_count, 10'd23);
      chk("t191_v", v_count, 10'd7);
      chk("t191_vid_on", vid_on, 1'b0);
      run_to(192);
      chk("t192_h", h_count, 10'd0);
      chk("t192_v", v_count, 10'd0);
      chk("vs_low_cnt", vs_low, 48);
      chk("hs_low_cnt", hs_low, 24);
      chk("fs_cnt_f0", fs_cnt, 1);
      run_to(193);
      chk("fs_cnt_f1", fs_cnt, 2);

      // Frame 1, mode 2: colour bars, 2 pixels per bar
      run_to(195);
      chk("bar0_white", {8'h0, blue, green, red}, 32'hFFFFFF);
      run_to(197);
      chk("bar1_yellow", {8'h0, blue, green, red}, 32'h00FFFF);
      run_to(199);
      chk("bar2_cyan", {8'h0, blue, green, red}, 32'hFFFF00);
      run_to(203);
      chk("bar4_magenta", {8'h0, blue, green, red}, 32'hFF00FF);
      run_to(205);
      chk("bar5_red", {8'h0, blue, green, red}, 32'h0000FF);
      run_to(210);
      chk("bar7_black", {8'h0, blue, green, red}, 32'h000000);
      chk("bar7_blank", blank_n, 1'b1);
      run_to(250);
      mode     = 2'd1;
      bg_color = 24'h123456;

      // Frame 2, mode 1: solid background on both instances
      run_to(387);
      chk("bg_rgb", {8'h0, blue, green, red}, 32'h123456);
      chk("bg_blank", blank_n, 1'b1);
      chk("bg4_rgb", {20'h0, blue4, green4, red4}, 32'h3A5);
      run_to(403);
      chk("bg_hblank", blank_n, 1'b0);
      chk("bg_hblank_rgb", {8'h0, blue, green, red}, 32'h0);
      chk("bg_hs_t403", hsync_n, 1'b1);
      chk("bg4_hs_t403", hsync_n4, 1'b0);
      chk("bg4_hblank", blank_n4, 1'b0);
      chk("bg4_hblank_rgb", {20'h0, blue4, green4, red4}, 32'h0);
      run_to(415);
      chk("pre_rst_rgb", {8'h0, blue, green, red}, 32'h123456);
      chk("pre_rst_blank", blank_n, 1'b1);

      // Async reset pulse between clock edges
      #1 reset = 1'b1;
      #1;
      chk("arst_rgb", {8'h0, blue, green, red}, 32'h0);
      chk("arst_blank", blank_n, 1'b0);
      chk("arst_hs", hsync_n, 1'b1);
      chk("arst_vs", vsync_n, 1'b1);
      #1 reset = 1'b0;
      chk("arst_h", h_count, 10'd0);
      chk("arst_v", v_count, 10'd0);
      tick_n = 0;
      run_to(1);
      chk("post_t1_blank", blank_n, 1'b0);
      chk("post4_t1_blank", blank_n4, 1'b1);
      run_to(2);
      chk("post_t2_blank", blank_n, 1'b0);
      chk("post4_t2_rgb", {20'h0, blue4, green4, red4}, 32'h3A5);
      run_to(3);
      chk("post_t3_blank", blank_n, 1'b1);
      chk("post_t3_rgb", {8'h0, blue, green, red}, 32'h123456);
      mode = 2'd3;
      run_to(30);
      chk("m3_deferred", {8'h0, blue, green, red}, 32'h123456);
      run_to(195);
      chk("m3_rgb", {8'h0, blue, green, red}, 32'h0);
      chk("m3_blank", blank_n, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
